// File: rtl/dflop_bank.sv
`default_nettype none
// ============================================================================
// Module      : dflop_bank
// Description : CHANNELS independent WIDTH-bit sample-and-hold registers with
//               per-channel load counter, load timestamp and change pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module dflop_bank #(
    parameter int               WIDTH     = 4,
    parameter int               CHANNELS  = 4,
    parameter int               CNT_WIDTH = 16,
    parameter int               TS_WIDTH  = 32,
    parameter bit               SAT_MODE  = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CHANNELS*WIDTH-1:0]       d,
    input  logic [CHANNELS-1:0]             en,
    input  logic [CHANNELS-1:0]             clr,
    output logic [CHANNELS*WIDTH-1:0]       q,
    output logic [CHANNELS*CNT_WIDTH-1:0]   count,
    output logic [CHANNELS*TS_WIDTH-1:0]    stamp,
    output logic [TS_WIDTH-1:0]             cycle,
    output logic [CHANNELS-1:0]             changed,
    output logic [CHANNELS-1:0]             sat
);

    localparam logic [TS_WIDTH-1:0]  c_ts_one  = TS_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    logic [TS_WIDTH-1:0] r_cycle;

    // Shared free-running cycle counter; wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + c_ts_one;
        end
    end

    assign cycle = r_cycle;

    genvar k;
    generate
        for (k = 0; k < CHANNELS; k++) begin : g_chan
            logic [WIDTH-1:0]     w_d;
            logic [WIDTH-1:0]     r_q;
            logic [CNT_WIDTH-1:0] r_cnt;
            logic [TS_WIDTH-1:0]  r_stamp;
            logic                 r_chg;
            logic                 r_sat;

            logic [WIDTH-1:0]     w_q_nxt;
            logic [CNT_WIDTH-1:0] w_cnt_nxt;
            logic [TS_WIDTH-1:0]  w_stamp_nxt;
            logic                 w_chg_nxt;
            logic                 w_sat_nxt;

            logic [CNT_WIDTH-1:0] w_cnt_inc;
            logic                 w_cnt_full;
            logic [CNT_WIDTH-1:0] w_cnt_load;
            logic                 w_sat_load;

            assign w_d        = d[k*WIDTH +: WIDTH];
            assign w_cnt_inc  = r_cnt + c_cnt_one;
            assign w_cnt_full = &r_cnt;

            if (SAT_MODE) begin : g_sat
                // Count sticks at all-ones; sat rises on the load that gets there.
                assign w_cnt_load = w_cnt_full ? r_cnt : w_cnt_inc;
                assign w_sat_load = r_sat | (&w_cnt_inc);
            end else begin : g_wrap
                assign w_cnt_load = w_cnt_inc;
                assign w_sat_load = r_sat | w_cnt_full;
            end

            always_comb begin
                w_q_nxt     = r_q;
                w_cnt_nxt   = r_cnt;
                w_stamp_nxt = r_stamp;
                w_sat_nxt   = r_sat;
                w_chg_nxt   = 1'b0;
                if (clr[k]) begin
                    w_q_nxt     = RESET_VAL;
                    w_cnt_nxt   = '0;
                    w_stamp_nxt = '0;
                    w_sat_nxt   = 1'b0;
                end else if (en[k]) begin
                    w_q_nxt     = w_d;
                    w_cnt_nxt   = w_cnt_load;
                    w_stamp_nxt = r_cycle;
                    w_sat_nxt   = w_sat_load;
                    w_chg_nxt   = (w_d != r_q);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q     <= RESET_VAL;
                    r_cnt   <= '0;
                    r_stamp <= '0;
                    r_chg   <= 1'b0;
                    r_sat   <= 1'b0;
                end else begin
                    r_q     <= w_q_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_stamp <= w_stamp_nxt;
                    r_chg   <= w_chg_nxt;
                    r_sat   <= w_sat_nxt;
                end
            end

            assign q[k*WIDTH +: WIDTH]              = r_q;
            assign count[k*CNT_WIDTH +: CNT_WIDTH]  = r_cnt;
            assign stamp[k*TS_WIDTH +: TS_WIDTH]    = r_stamp;
            assign changed[k]                       = r_chg;
            assign sat[k]                           = r_sat;
        end
    endgenerate

endmodule
`default_nettype wire
